// File: rtl/mem_bus_arb.sv
// Two-master (CPU m0, DMA m1) to one memory slave bus arbiter with ack-wait timeout.
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests by last grant instead of fixed DMA priority.

module mem_bus_arb_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_i,
  input  logic s_ack_i,
  input  logic expire_i,
  output logic ack_o,
  output logic err_o
);
  logic err_q;

  assign ack_o = sel_i & s_ack_i;
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= sel_i & expire_i;
  end
endmodule

module mem_bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc,
  input  logic        m0_we,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc,
  input  logic        m1_we,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_data_o,
  output logic        s_cyc,
  output logic        s_we,
  output logic [3:0]  s_strb,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_o,
  input  logic        s_ack,
  input  logic [31:0] s_data_i,
  output logic [1:0]  gnt
);
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_e;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         expire;
  mreq_t [1:0]  mreq;
  mreq_t        sreq;
  logic  [1:0]  ack_v, err_v;

  assign mreq[0] = {m0_cyc, m0_we, m0_strb, m0_addr, m0_data_i};
  assign mreq[1] = {m1_cyc, m1_we, m1_strb, m1_addr, m1_data_i};

  // Slave side is a pure mux of the granted master; all-zero when idle.
  assign sreq     = (state_q == IDLE) ? '0 : mreq[state_q[1]];
  assign s_cyc    = sreq.cyc;
  assign s_we     = sreq.we;
  assign s_strb   = sreq.strb;
  assign s_addr   = sreq.addr;
  assign s_data_o = sreq.data;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign gnt       = state_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        last_q <= 1'b0;
    else if (state_d != state_q && state_d != IDLE)    last_q <= (state_d == GNT1);
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_q ? GNT0 : GNT1;
`else
          state_d = GNT1;
`endif
        end
        else if (m1_cyc) state_d = GNT1;
        else if (m0_cyc) state_d = GNT0;
      end
      GNT0:    if (!m0_cyc) state_d = m1_cyc ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc) state_d = m0_cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Expiry is detected one count early so the registered err lands exactly TIMEOUT cycles in.
  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    expire = 1'b0;
    if (state_q == IDLE || state_d != state_q || s_ack) begin
      cnt_d = '0;
    end
    else if (cnt_q == TO_M1) begin
      cnt_d  = '0;
      expire = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end
    else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    mem_bus_arb_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel_i    (state_q[g]),
      .s_ack_i  (s_ack),
      .expire_i (expire),
      .ack_o    (ack_v[g]),
      .err_o    (err_v[g])
    );
  end

  assign m0_ack = ack_v[0];
  assign m1_ack = ack_v[1];
  assign m0_err = err_v[0];
  assign m1_err = err_v[1];
endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, the ack-wait limit in cycles (1..255, held in an 8-bit counter).
REQ-002 SHALL provide ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_cyc, m0_we  in  1 each  CPU master request/write.
- m0_strb  in  4  CPU byte strobes.
- m0_addr, m0_data_i  in  32 each  CPU address/write data.
- m0_ack, m0_err  out  1 each  CPU ack/timeout error.
- m0_data_o  out  32  CPU read data.
- m1_cyc, m1_we, m1_strb, m1_addr, m1_data_i, m1_ack, m1_err, m1_data_o: same as m0_*, for the DMA master.
- s_cyc, s_we  out  1 each  to memory slave.
- s_strb  out  4  to memory slave.
- s_addr, s_data_o  out  32 each  to memory slave.
- s_ack  in  1  slave ack.
- s_data_i  in  32  slave read data.
- gnt  out  2  one-hot grant status: bit0 = CPU, bit1 = DMA.

Function
REQ-003 SHALL implement FSM states IDLE, GNT0, GNT1; gnt SHALL equal 2'b00, 2'b01 and 2'b10 respectively.
REQ-004 In IDLE, a request with m0_cyc or m1_cyc high SHALL move the FSM to the selected GNTx on the next edge; arbitration latency is 1 cycle, and s_cyc SHALL be low in IDLE.
REQ-005 In GNTx, s_cyc/s_we/s_strb/s_addr/s_data_o SHALL combinationally equal the signals of master x; s_cyc SHALL equal mx_cyc.
REQ-006 Non-granted master outputs:
- s_ack SHALL route only to mx_ack of the granted master; the other master's ack SHALL be 0.
- s_data_i SHALL drive both mx_data_o.
- In IDLE, all slave outputs SHALL be 0.
REQ-007 Grant SHALL NOT be preempted; the FSM stays in GNTx while mx_cyc is high.
REQ-008 In GNTx with mx_cyc low, the FSM SHALL go to GNTy if the other master's cyc is high, else to IDLE.
REQ-009 A master dropping cyc and the other requesting in the same cycle SHALL hand over with zero dead cycles.
REQ-010 Both cyc high in IDLE SHALL be resolved per REQ-016/REQ-017.
REQ-011 An 8-bit wait counter SHALL:
- clear on entry to any GNTx, on s_ack, and in IDLE;
- otherwise increment each cycle in GNTx.
REQ-012 When the wait counter equals TIMEOUT, mx_err of the granted master SHALL pulse high for 1 cycle and the counter SHALL clear; the grant is unchanged.
REQ-013 s_ack and expiry in the same cycle SHALL produce ack only, with no err.
REQ-014 s_ack arriving in IDLE SHALL be ignored: no master ack.

Reset
REQ-015 While rst_n is low, and asynchronously on its assertion (including mid-transfer):
- FSM SHALL return to IDLE.
- gnt, the wait counter, m0_err/m1_err, m0_ack/m1_ack and s_cyc SHALL be 0.
- The last-grant register SHALL be cleared to 0 (CPU last).
- Arbitration SHALL resume on the first edge after deassertion.

Configuration
REQ-016 With macro ARB_ROUND_ROBIN_EN defined:
- A last-grant register SHALL update on every entry to GNTx.
- Simultaneous requests SHALL be granted to the master not last granted.
- The REQ-009 handover SHALL be unchanged.
REQ-017 Without ARB_ROUND_ROBIN_EN, simultaneous requests in IDLE SHALL always grant DMA (m1), and no last-grant register SHALL exist.

Verification
REQ-018 CPU only:
- Stimulus: m0_cyc=1, we=1, addr=0x0000_1000, data=0xDEAD_BEEF; s_ack after 2 cycles.
- Response: gnt=01 one cycle after the request; s_addr=0x0000_1000; m0_ack 1 cycle; m1_ack=0.
REQ-019 Simultaneous request from IDLE, both masters cyc=1:
- Default build: gnt=10.
- With ARB_ROUND_ROBIN_EN after reset: gnt=10 (last=CPU), then after m1 drops, gnt=01.
REQ-020 No preemption and handover:
- DMA granted for 4 acks, with m0_cyc raised mid-burst: gnt stays 10.
- m1_cyc drops: gnt=01 on the next edge, with no IDLE cycle.
REQ-021 Timeout, TIMEOUT=8:
- Stimulus: m0 granted, s_ack never asserted.
- Response: m0_err pulses 1 cycle at 8 cycles after grant, and again at 16 cycles; gnt stays 01.
REQ-022 Reset mid-operation:
- Stimulus: rst_n low during GNT1 with s_ack pending.
- Response: gnt=00, s_cyc=0 and m1_ack=0 immediately.
- After release with m0_cyc=1: gnt=01 after 1 cycle.
